resize_engine: RTL and testbench

- Parametrised image-resize engine. Reads a source greyscale image from a synchronous ROM port and writes the resized image, in raster order, to the video frame buffer write port.
- Supports four latched modes: replicate zoom-in, decimate zoom-out, block-average zoom-out and 1:1 copy.
- Sits between the control FSM (start/done) and the ROM / frame-buffer memories.
- Adds two things the previous resizer lacked: write backpressure and configurable scale, size, pixel width and read latency.

---
 rtl/resize_pkg.sv | 17 +
 rtl/resize_addr_gen.sv | 134 +++++++++++++
 rtl/resize_engine.sv | 150 +++++++++++++++
 tb/tb_resize_engine.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/resize_pkg.sv
// Shared encodings for the resize engine: operating modes and FSM states.
package resize_pkg;

    // Resize modes, sampled on an accepted start
    localparam logic [1:0] MODE_ZOOM_IN  = 2'b00;
    localparam logic [1:0] MODE_DECIMATE = 2'b01;
    localparam logic [1:0] MODE_AVERAGE  = 2'b10;
    localparam logic [1:0] MODE_COPY     = 2'b11;

    // Control FSM states
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

endpackage

// File: rtl/resize_addr_gen.sv
// Address generation for the resize engine: destination raster counters,
// last-pixel detection, FxF block offsets and incremental source addressing
// (row base plus column offset, no multiplier).
module resize_addr_gen
    import resize_pkg::*;
#(
    parameter int SRC_W      = 160,
    parameter int SRC_H      = 120,
    parameter int SCALE_LOG2 = 1,
    parameter int SRC_AW     = $clog2(SRC_W * SRC_H),
    parameter int DST_AW     = $clog2(SRC_W * SRC_H * (1 << SCALE_LOG2) * (1 << SCALE_LOG2))
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        i_mode,
    input  logic              i_clear,
    input  logic              i_rd_step,
    input  logic              i_pix_adv,
    output logic [SRC_AW-1:0] o_src_addr,
    output logic [DST_AW-1:0] o_dst_addr,
    output logic              o_last_rd,
    output logic              o_last_pix
);

    localparam int F  = 1 << SCALE_LOG2;
    localparam int XW = $clog2(SRC_W * F + 1);
    localparam int YW = $clog2(SRC_H * F + 1);

    localparam logic [SRC_AW-1:0] ROW_STEP   = SRC_AW'(SRC_W);
    localparam logic [SRC_AW-1:0] ROW_STEP_F = SRC_AW'(SRC_W * F);

    // Last destination column/row index for each destination size
    localparam logic [XW-1:0] X_MAX_IN  = XW'(SRC_W * F - 1);
    localparam logic [XW-1:0] X_MAX_OUT = XW'(SRC_W / F - 1);
    localparam logic [XW-1:0] X_MAX_1   = XW'(SRC_W - 1);
    localparam logic [YW-1:0] Y_MAX_IN  = YW'(SRC_H * F - 1);
    localparam logic [YW-1:0] Y_MAX_OUT = YW'(SRC_H / F - 1);
    localparam logic [YW-1:0] Y_MAX_1   = YW'(SRC_H - 1);

    logic [XW-1:0]         r_dx;
    logic [YW-1:0]         r_dy;
    logic [SRC_AW-1:0]     r_row_base;
    logic [SRC_AW-1:0]     r_blk_row;
    logic [SCALE_LOG2-1:0] r_bx;
    logic [SCALE_LOG2-1:0] r_by;
    logic [DST_AW-1:0]     r_dst_addr;

    logic [XW-1:0]         w_dx_max;
    logic [YW-1:0]         w_dy_max;
    logic [XW-1:0]         w_col;
    logic [SRC_AW-1:0]     w_row_step;
    logic                  w_avg;

    // Per-mode destination size, source column and row-base increment
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_avg      = (i_mode == MODE_AVERAGE);
        w_dx_max   = X_MAX_1;
        w_dy_max   = Y_MAX_1;
        w_col      = r_dx;
        w_row_step = ROW_STEP;
        case (i_mode)
            MODE_ZOOM_IN: begin
                w_dx_max   = X_MAX_IN;
                w_dy_max   = Y_MAX_IN;
                w_col      = r_dx >> SCALE_LOG2;
                // Source row advances only after F destination rows
                w_row_step = (&r_dy[SCALE_LOG2-1:0]) ? ROW_STEP : '0;
            end
            MODE_DECIMATE, MODE_AVERAGE: begin
                w_dx_max   = X_MAX_OUT;
                w_dy_max   = Y_MAX_OUT;
                w_col      = r_dx << SCALE_LOG2;
                w_row_step = ROW_STEP_F;
            end
            default: ;
        endcase
    end

    // Block offsets stay zero outside AVERAGE, so one adder serves every mode
    assign o_last_rd  = !w_avg || ((&r_bx) && (&r_by));
    assign o_last_pix = (r_dx == w_dx_max) && (r_dy == w_dy_max);
    assign o_src_addr = r_row_base + r_blk_row + SRC_AW'(w_col) + SRC_AW'(r_bx);
    assign o_dst_addr = r_dst_addr;

    // Block offset counters: row-major scan of the FxF block, one step per read
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n || i_clear) begin
            r_bx      <= '0;
            r_by      <= '0;
            r_blk_row <= '0;
        end else if (i_rd_step) begin
            if (o_last_rd) begin
                r_bx      <= '0;
                r_by      <= '0;
                r_blk_row <= '0;
            end else if (&r_bx) begin
                r_bx      <= '0;
                r_by      <= r_by + SCALE_LOG2'(1);
                r_blk_row <= r_blk_row + ROW_STEP;
            end else begin
                r_bx <= r_bx + SCALE_LOG2'(1);
            end
        end
    end

    // Destination raster and source row base, advanced on each accepted write
    always_ff @(posedge clk) begin
        if (!reset_n || i_clear) begin
            r_dx       <= '0;
            r_dy       <= '0;
            r_row_base <= '0;
            r_dst_addr <= '0;
        end else if (i_pix_adv) begin
            if (o_last_pix) begin
                r_dx       <= '0;
                r_dy       <= '0;
                r_row_base <= '0;
                r_dst_addr <= '0;
            end else begin
                r_dst_addr <= r_dst_addr + DST_AW'(1);
                if (r_dx == w_dx_max) begin
                    r_dx       <= '0;
                    r_dy       <= r_dy + YW'(1);
                    r_row_base <= r_row_base + w_row_step;
                end else begin
                    r_dx <= r_dx + XW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/resize_engine.sv
// Image resize engine: reads a greyscale source image from a synchronous ROM
// and writes the resized image in raster order to the frame buffer, honouring
// write backpressure. Holds the control FSM, read-valid pipe, block
// accumulator and output pixel register.
module resize_engine
    import resize_pkg::*;
#(
    parameter int SRC_W      = 160,
    parameter int SRC_H      = 120,
    parameter int PIX_W      = 8,
    parameter int SCALE_LOG2 = 1,
    parameter int RD_LAT     = 1,
    parameter int SRC_AW     = $clog2(SRC_W * SRC_H),
    parameter int DST_AW     = $clog2(SRC_W * SRC_H * (1 << SCALE_LOG2) * (1 << SCALE_LOG2))
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        mode,
    output logic              busy,
    output logic              done,
    output logic              src_rd_en,
    output logic [SRC_AW-1:0] src_addr,
    input  logic [PIX_W-1:0]  src_data,
    output logic              dst_wren,
    output logic [DST_AW-1:0] dst_addr,
    output logic [PIX_W-1:0]  dst_data,
    input  logic              dst_ready
);

    // Sum of F*F pixels needs 2*S extra bits; the >>2S result always fits PIX_W
    localparam int ACC_W = PIX_W + 2 * SCALE_LOG2;

    logic [2:0]        r_state;
    logic [1:0]        r_mode;
    logic [1:0]        r_wait_cnt;
    logic [RD_LAT-1:0] r_vpipe;
    logic [ACC_W-1:0]  r_acc;
    logic [PIX_W-1:0]  r_pix;

    logic              w_start_ok;
    logic              w_rd;
    logic              w_wr;
    logic              w_accept;
    logic              w_wait_last;
    logic              w_valid;
    logic [ACC_W-1:0]  w_acc_next;
    logic              w_last_rd;
    logic              w_last_pix;
    logic [SRC_AW-1:0] w_src_addr;
    logic [DST_AW-1:0] w_dst_addr;

    resize_addr_gen #(
        .SRC_W      (SRC_W),
        .SRC_H      (SRC_H),
        .SCALE_LOG2 (SCALE_LOG2),
        .SRC_AW     (SRC_AW),
        .DST_AW     (DST_AW)
    ) u_addr_gen (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_mode     (r_mode),
        .i_clear    (w_start_ok),
        .i_rd_step  (w_rd),
        .i_pix_adv  (w_accept),
        .o_src_addr (w_src_addr),
        .o_dst_addr (w_dst_addr),
        .o_last_rd  (w_last_rd),
        .o_last_pix (w_last_pix)
    );

    // A start in DONE is accepted so back-to-back frames lose no cycle
    assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_rd        = (r_state == S_RD);
    assign w_wr        = (r_state == S_WR);
    assign w_accept    = w_wr && dst_ready;
    assign w_wait_last = (r_state == S_WAIT) && (r_wait_cnt == 2'(RD_LAT - 1));
    assign w_valid     = r_vpipe[RD_LAT-1];
    assign w_acc_next  = r_acc + (w_valid ? ACC_W'(src_data) : '0);

    // Outputs are gated by state so reset or idle drives every port to zero
    assign busy      = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done      = (r_state == S_DONE);
    assign src_rd_en = w_rd;
    assign src_addr  = w_rd ? w_src_addr : '0;
    assign dst_wren  = w_wr;
    assign dst_addr  = w_wr ? w_dst_addr : '0;
    assign dst_data  = w_wr ? r_pix : '0;

    // Control FSM: IDLE -> RD -> WAIT -> WR -> (RD | DONE) -> IDLE
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_mode     <= MODE_ZOOM_IN;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start_ok) begin
                        r_mode  <= mode;
                        r_state <= S_RD;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RD: begin
                    if (w_last_rd) begin
                        r_wait_cnt <= '0;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_wait_last) begin
                        r_state <= S_WR;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 2'd1;
                    end
                end
                S_WR: begin
                    if (dst_ready) begin
                        r_state <= w_last_pix ? S_DONE : S_RD;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Read-valid pipe, block accumulator and output pixel capture
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_vpipe <= '0;
            r_acc   <= '0;
            r_pix   <= '0;
        end else begin
            r_vpipe <= (r_vpipe << 1) | RD_LAT'(w_rd);
            if (w_start_ok || w_accept) begin
                r_acc <= '0;
            end else if (w_valid) begin
                r_acc <= w_acc_next;
            end
            // The last word arrives in the final WAIT cycle, so fold it in directly
            if (w_wait_last) begin
                r_pix <= (r_mode == MODE_AVERAGE) ?
                         PIX_W'(w_acc_next >> (2 * SCALE_LOG2)) : src_data;
            end
        end
    end

endmodule

// File: tb/tb_resize_engine.sv
// Self-checking bench for resize_engine on a 4x2 source, F=2, RD_LAT=1.
// Expected writes are pushed to a scoreboard queue when a run is started and
// compared in order against the writes the DUT has accepted.
module tb_resize_engine;

    localparam int SRC_W      = 4;
    localparam int SRC_H      = 2;
    localparam int PIX_W      = 8;
    localparam int SCALE_LOG2 = 1;
    localparam int RD_LAT     = 1;
    localparam int F          = 2;
    localparam int SRC_AW     = 3;
    localparam int DST_AW     = 5;

    localparam logic [1:0] M_ZOOM = 2'b00;
    localparam logic [1:0] M_DEC  = 2'b01;
    localparam logic [1:0] M_AVG  = 2'b10;
    localparam logic [1:0] M_COPY = 2'b11;

    logic              clk;
    logic              reset_n;
    logic              start;
    logic [1:0]        mode;
    logic              busy;
    logic              done;
    logic              src_rd_en;
    logic [SRC_AW-1:0] src_addr;
    logic [PIX_W-1:0]  src_data;
    logic              dst_wren;
    logic [DST_AW-1:0] dst_addr;
    logic [PIX_W-1:0]  dst_data;
    logic              dst_ready;

    typedef struct packed {
        logic [DST_AW-1:0] addr;
        logic [PIX_W-1:0]  data;
    } wr_t;

    wr_t exp_q[$];
    wr_t got_q[$];
    int  checks = 0;
    int  errors = 0;

    logic [PIX_W-1:0] rom [SRC_W*SRC_H];
    logic [PIX_W-1:0] rom_q;

    resize_engine #(
        .SRC_W      (SRC_W),
        .SRC_H      (SRC_H),
        .PIX_W      (PIX_W),
        .SCALE_LOG2 (SCALE_LOG2),
        .RD_LAT     (RD_LAT),
        .SRC_AW     (SRC_AW),
        .DST_AW     (DST_AW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .mode      (mode),
        .busy      (busy),
        .done      (done),
        .src_rd_en (src_rd_en),
        .src_addr  (src_addr),
        .src_data  (src_data),
        .dst_wren  (dst_wren),
        .dst_addr  (dst_addr),
        .dst_data  (dst_data),
        .dst_ready (dst_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM, one cycle of latency
    always @(posedge clk) if (src_rd_en) rom_q <= rom[src_addr];
    assign src_data = rom_q;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic load_ramp();
        for (int i = 0; i < SRC_W * SRC_H; i++) rom[i] = PIX_W'(i * 10);
    endtask

    // Reference model of every destination pixel, pushed in raster order
    task automatic push_expected(input logic [1:0] m);
        int  dw = SRC_W;
        int  dh = SRC_H;
        int  pix;
        wr_t e;
        if (m == M_ZOOM) begin
            dw = SRC_W * F; dh = SRC_H * F;
        end else if (m == M_DEC || m == M_AVG) begin
            dw = SRC_W / F; dh = SRC_H / F;
        end
        for (int y = 0; y < dh; y++) begin
            for (int x = 0; x < dw; x++) begin
                case (m)
                    M_ZOOM: pix = int'(rom[(y / F) * SRC_W + x / F]);
                    M_DEC:  pix = int'(rom[(y * F) * SRC_W + x * F]);
                    M_AVG: begin
                        pix = 0;
                        for (int j = 0; j < F; j++)
                            for (int i = 0; i < F; i++)
                                pix += int'(rom[(y * F + j) * SRC_W + x * F + i]);
                        pix = pix / (F * F);
                    end
                    default: pix = int'(rom[y * SRC_W + x]);
                endcase
                e.addr = DST_AW'(y * dw + x);
                e.data = PIX_W'(pix);
                exp_q.push_back(e);
            end
        end
    endtask

    // Starts a run and collects accepted writes into got_q. Cycle c=0 is the
    // cycle after the accepting edge. Optional stall, duplicate start and abort.
    task automatic run(input logic [1:0] m, input int stall_addr, input int stall_len,
                       input logic [PIX_W-1:0] stall_data, input int dup_cyc,
                       input int abort_after, input int budget,
                       output int done_cyc, output int stall_seen,
                       output int stall_bad, output int busy_bad);
        wr_t w;
        int  n = 0;
        done_cyc = -1; stall_seen = 0; stall_bad = 0; busy_bad = 0;
        mode = m; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < budget; c++) begin
            start     = (c == dup_cyc);
            mode      = (c == dup_cyc) ? ~m : m;
            dst_ready = 1'b1;
            if (dst_wren && int'(dst_addr) == stall_addr && stall_seen < stall_len) begin
                dst_ready = 1'b0;
                stall_seen++;
                if (src_rd_en || dst_data !== stall_data) stall_bad++;
            end
            if (done) begin
                if (busy) busy_bad++;
                done_cyc = c;
            end else if (!busy) begin
                busy_bad++;
            end
            if (dst_wren && dst_ready) begin
                w.addr = dst_addr; w.data = dst_data;
                got_q.push_back(w);
                n++;
            end
            @(posedge clk); #1;
            if (done_cyc >= 0) break;
            if (n == abort_after) begin
                reset_n = 1'b0; start = 1'b0;
                @(posedge clk); #1;
                break;
            end
        end
        start = 1'b0; mode = m; dst_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; mode = M_ZOOM; dst_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, src_rd_en, src_addr, dst_wren, dst_addr, dst_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs busy=%b done=%b rd=%b sa=%0d wr=%b da=%0d dd=%0d expected all 0",
                     busy, done, src_rd_en, src_addr, dst_wren, dst_addr, dst_data);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_copy();
        int dc, ss, sb, bb;
        wr_t e, g;
        load_ramp();
        push_expected(M_COPY);
        run(M_COPY, -1, 0, '0, -1, -1, 100, dc, ss, sb, bb);
        checks++;
        if (got_q.size() != 8) begin
            errors++; $display("FAIL copy_count got=%0d expected=8", got_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL copy_wr got addr=%0d data=%0d expected addr=%0d data=%0d",
                         g.addr, g.data, e.addr, e.data);
            end
        end
        exp_q.delete(); got_q.delete();
        checks++;
        if (dc != 24) begin errors++; $display("FAIL copy_done_cycle got=%0d expected=24", dc); end
        checks++;
        if (bb != 0) begin errors++; $display("FAIL copy_busy got=%0d bad cycles expected=0", bb); end
    endtask

    task automatic test_zoom_in();
        int dc, ss, sb, bb;
        wr_t e, g;
        load_ramp();
        push_expected(M_ZOOM);
        run(M_ZOOM, -1, 0, '0, -1, -1, 200, dc, ss, sb, bb);
        checks++;
        if (got_q.size() != 32) begin
            errors++; $display("FAIL zoom_count got=%0d expected=32", got_q.size());
        end else begin
            checks++;
            if (got_q[9].data !== 8'd0 || got_q[10].data !== 8'd10 || got_q[31].data !== 8'd70 ||
                got_q[0].data !== 8'd0 || got_q[1].data !== 8'd0) begin
                errors++;
                $display("FAIL zoom_points got d9=%0d d10=%0d d31=%0d d0=%0d d1=%0d expected 0 10 70 0 0",
                         got_q[9].data, got_q[10].data, got_q[31].data, got_q[0].data, got_q[1].data);
            end
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL zoom_wr got addr=%0d data=%0d expected addr=%0d data=%0d",
                         g.addr, g.data, e.addr, e.data);
            end
        end
        exp_q.delete(); got_q.delete();
        checks++;
        if (dc != 96) begin errors++; $display("FAIL zoom_done_cycle got=%0d expected=96", dc); end
    endtask

    task automatic test_decimate_average();
        int dc, ss, sb, bb;
        wr_t g;
        load_ramp();
        run(M_DEC, -1, 0, '0, -1, -1, 100, dc, ss, sb, bb);
        checks++;
        if (got_q.size() != 2 || dc != 6) begin
            errors++; $display("FAIL dec_shape got writes=%0d done=%0d expected 2 6", got_q.size(), dc);
        end else begin
            g = got_q[0]; checks++;
            if (g.addr !== 5'd0 || g.data !== 8'd0) begin
                errors++; $display("FAIL dec_px0 got addr=%0d data=%0d expected 0 0", g.addr, g.data);
            end
            g = got_q[1]; checks++;
            if (g.addr !== 5'd1 || g.data !== 8'd20) begin
                errors++; $display("FAIL dec_px1 got addr=%0d data=%0d expected 1 20", g.addr, g.data);
            end
        end
        got_q.delete();
        run(M_AVG, -1, 0, '0, -1, -1, 100, dc, ss, sb, bb);
        checks++;
        if (got_q.size() != 2 || dc != 12) begin
            errors++; $display("FAIL avg_shape got writes=%0d done=%0d expected 2 12", got_q.size(), dc);
        end else begin
            g = got_q[0]; checks++;
            if (g.addr !== 5'd0 || g.data !== 8'd25) begin
                errors++; $display("FAIL avg_px0 got addr=%0d data=%0d expected 0 25", g.addr, g.data);
            end
            g = got_q[1]; checks++;
            if (g.addr !== 5'd1 || g.data !== 8'd45) begin
                errors++; $display("FAIL avg_px1 got addr=%0d data=%0d expected 1 45", g.addr, g.data);
            end
        end
        got_q.delete();
    endtask

    task automatic test_average_range();
        int dc, ss, sb, bb;
        wr_t e, g;
        for (int i = 0; i < SRC_W * SRC_H; i++) rom[i] = 8'd255;
        push_expected(M_AVG);
        run(M_AVG, -1, 0, '0, -1, -1, 100, dc, ss, sb, bb);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (got_q.size() <= i || got_q[i].data !== 8'd255) begin
                errors++; $display("FAIL avg_max px%0d got size=%0d expected data 255", i, got_q.size());
            end
        end
        exp_q.delete(); got_q.delete();
        // Block 0 holds {1,1,1,2}, block 1 holds {3,3,3,4}
        rom[0] = 8'd1; rom[1] = 8'd1; rom[2] = 8'd3; rom[3] = 8'd3;
        rom[4] = 8'd1; rom[5] = 8'd2; rom[6] = 8'd3; rom[7] = 8'd4;
        push_expected(M_AVG);
        run(M_AVG, -1, 0, '0, -1, -1, 100, dc, ss, sb, bb);
        checks++;
        if (got_q.size() != 2) begin
            errors++; $display("FAIL avg_floor_count got=%0d expected=2", got_q.size());
        end else begin
            checks++;
            if (got_q[0].data !== 8'd1) begin
                errors++; $display("FAIL avg_floor got=%0d expected=1", got_q[0].data);
            end
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL avg_floor_wr got addr=%0d data=%0d expected addr=%0d data=%0d",
                         g.addr, g.data, e.addr, e.data);
            end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_backpressure();
        int dc, ss, sb, bb;
        wr_t e, g;
        load_ramp();
        push_expected(M_COPY);
        run(M_COPY, 3, 5, 8'd30, -1, -1, 100, dc, ss, sb, bb);
        checks++;
        if (ss != 5 || sb != 0) begin
            errors++; $display("FAIL stall_hold got stalled=%0d bad=%0d expected 5 0", ss, sb);
        end
        checks++;
        if (got_q.size() != 8) begin
            errors++; $display("FAIL stall_count got=%0d expected=8", got_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL stall_wr got addr=%0d data=%0d expected addr=%0d data=%0d",
                         g.addr, g.data, e.addr, e.data);
            end
        end
        exp_q.delete(); got_q.delete();
        checks++;
        if (dc != 29) begin errors++; $display("FAIL stall_done_cycle got=%0d expected=29", dc); end
    endtask

    task automatic test_start_while_busy();
        int dc, ss, sb, bb;
        wr_t e, g;
        load_ramp();
        push_expected(M_COPY);
        run(M_COPY, -1, 0, '0, 5, -1, 100, dc, ss, sb, bb);
        checks++;
        if (got_q.size() != 8 || dc != 24) begin
            errors++; $display("FAIL busy_start got writes=%0d done=%0d expected 8 24", got_q.size(), dc);
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL busy_start_wr got addr=%0d data=%0d expected addr=%0d data=%0d",
                         g.addr, g.data, e.addr, e.data);
            end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_reset_mid_op();
        int dc, ss, sb, bb;
        int bad = 0;
        wr_t e, g;
        load_ramp();
        push_expected(M_COPY);
        run(M_COPY, -1, 0, '0, -1, 4, 100, dc, ss, sb, bb);
        checks++;
        if ({busy, done, src_rd_en, src_addr, dst_wren, dst_addr, dst_data} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs busy=%b done=%b rd=%b sa=%0d wr=%b da=%0d dd=%0d expected all 0",
                     busy, done, src_rd_en, src_addr, dst_wren, dst_addr, dst_data);
        end
        checks++;
        if (got_q.size() != 4 || dc != -1) begin
            errors++; $display("FAIL midreset_partial got writes=%0d done=%0d expected 4 -1", got_q.size(), dc);
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL midreset_wr got addr=%0d data=%0d expected addr=%0d data=%0d",
                         g.addr, g.data, e.addr, e.data);
            end
        end
        exp_q.delete(); got_q.delete();
        reset_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (done || dst_wren || src_rd_en || busy) bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL midreset_quiet got=%0d active cycles expected=0", bad); end
        push_expected(M_COPY);
        run(M_COPY, -1, 0, '0, -1, -1, 100, dc, ss, sb, bb);
        checks++;
        if (got_q.size() != 8 || dc != 24) begin
            errors++; $display("FAIL rerun_shape got writes=%0d done=%0d expected 8 24", got_q.size(), dc);
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL rerun_wr got addr=%0d data=%0d expected addr=%0d data=%0d",
                         g.addr, g.data, e.addr, e.data);
            end
        end
        exp_q.delete(); got_q.delete();
    endtask

    initial begin
        test_reset();
        test_copy();
        test_zoom_in();
        test_decimate_average();
        test_average_range();
        test_backpressure();
        test_start_while_busy();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
